// File: rtl/fft_input_loader_pkg.sv
// Shared FFT constants, the loader state encoding and the bit-reversal helper
// used to scatter a natural-order frame into bank A.
package fft_consts;

  parameter int DATA_W = 16;
  parameter int N_LOG2 = 3;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    FLUSH  = 2'd1,
    START  = 2'd2,
    RESULT = 2'd3
  } ld_state_e;

  function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] x);
    logic [N_LOG2-1:0] r;
    for (int i = 0; i < N_LOG2; i++) begin
      r[i] = x[N_LOG2-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_input_loader_if.sv
// Sample stream, bank-A write port and AGU handshake of the FFT input loader.
interface fft_input_loader_if #(
  parameter int DATA_W = fft_consts::DATA_W,
  parameter int N_LOG2 = fft_consts::N_LOG2
);

  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_re;
  logic [DATA_W-1:0] s_im;
  logic              s_last;
  logic              wr_en;
  logic [N_LOG2-1:0] wr_addr;
  logic [DATA_W-1:0] wr_re;
  logic [DATA_W-1:0] wr_im;
  logic              fft_start;
  logic              fft_done;
  logic              result_valid;
  logic              result_bank;
  logic              frame_err;

  // The loader itself.
  modport slave (
    input  s_valid, s_re, s_im, s_last, fft_done,
    output s_ready, wr_en, wr_addr, wr_re, wr_im,
           fft_start, result_valid, result_bank, frame_err
  );

  // Sample source, bank-A memory and AGU seen together.
  modport master (
    output s_valid, s_re, s_im, s_last, fft_done,
    input  s_ready, wr_en, wr_addr, wr_re, wr_im,
           fft_start, result_valid, result_bank, frame_err
  );

endinterface

// File: rtl/fft_input_loader.sv
// Loads one N-sample complex frame into bank A at bit-reversed addresses,
// then holds the AGU start level until done and pulses result_valid.
module fft_input_loader #(
  parameter int DATA_W = fft_consts::DATA_W,
  parameter int N_LOG2 = fft_consts::N_LOG2
) (
  input logic               clk,
  input logic               rst_n,
  fft_input_loader_if.slave bus
);

  import fft_consts::ld_state_e;
  import fft_consts::bitrev;

  localparam int                N        = 1 << N_LOG2;
  localparam logic [N_LOG2-1:0] CNT_LAST = N_LOG2'(N - 1);
  localparam logic [N_LOG2-1:0] CNT_ONE  = N_LOG2'(1);

  ld_state_e         state_q, state_d;
  logic              ready_q;
  logic [N_LOG2-1:0] cnt_q, cnt_d;
  logic              wr_en_q;
  logic [N_LOG2-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_re_q, wr_im_q;
  logic              frame_err_q;
  logic              fft_start_c, result_valid_c;
  logic              accept, at_last;

  assign accept  = bus.s_valid && ready_q;
  assign at_last = (cnt_q == CNT_LAST);
  assign cnt_d   = cnt_q + CNT_ONE;

  // ready is registered from the next state so it is low throughout reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= fft_consts::LOAD;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == fft_consts::LOAD);
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      fft_consts::LOAD:   if (accept && at_last) state_d = fft_consts::FLUSH;
      fft_consts::FLUSH:  state_d = fft_consts::START;
      fft_consts::START:  if (bus.fft_done) state_d = fft_consts::RESULT;
      fft_consts::RESULT: state_d = fft_consts::LOAD;
      default:            state_d = fft_consts::LOAD;
    endcase
  end

  always_comb begin
    fft_start_c    = 1'b0;
    result_valid_c = 1'b0;
    case (state_q)
      fft_consts::START:  fft_start_c    = 1'b1;
      fft_consts::RESULT: result_valid_c = 1'b1;
      default: ;
    endcase
  end

  // Sample counter and registered bank-A write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_re_q     <= '0;
      wr_im_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      wr_en_q     <= accept;
      frame_err_q <= accept && (bus.s_last != at_last);
      if (accept) begin
        cnt_q     <= cnt_d;
        wr_addr_q <= bitrev(cnt_q);
        wr_re_q   <= bus.s_re;
        wr_im_q   <= bus.s_im;
      end
    end
  end

  assign bus.s_ready      = ready_q;
  assign bus.wr_en        = wr_en_q;
  assign bus.wr_addr      = wr_addr_q;
  assign bus.wr_re        = wr_re_q;
  assign bus.wr_im        = wr_im_q;
  assign bus.fft_start    = fft_start_c;
  assign bus.result_valid = result_valid_c;
  assign bus.result_bank  = 1'(N_LOG2 % 2);
  assign bus.frame_err    = frame_err_q;

endmodule
